mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundles the request/response and RAM bus signals of mem_access_unit.
// master: the access unit's view; slave: the CDEC control unit plus RAM side.
// Carries no logic; clock and reset stay outside as plain ports.
interface mem_access_unit_if;
   logic       fetch_req;
   logic [7:0] fetch_pc;
   logic       instr_valid;
   logic [7:0] instr_opcode;
   logic [7:0] instr_operand;
   logic       instr_len;
   logic       data_req;
   logic       data_we;
   logic [7:0] data_adrs;
   logic [7:0] data_wdata;
   logic       data_valid;
   logic [7:0] data_rdata;
   logic       data_err;
   logic       busy;
   logic [7:0] mem_adrs;
   logic [7:0] mem_data;
   logic       mem_wr_en;
   logic [7:0] mem_q;

   modport master (
      input  fetch_req, fetch_pc, data_req, data_we, data_adrs, data_wdata, mem_q,
      output instr_valid, instr_opcode, instr_operand, instr_len,
             data_valid, data_rdata, data_err, busy, mem_adrs, mem_data, mem_wr_en
   );

   modport slave (
      output fetch_req, fetch_pc, data_req, data_we, data_adrs, data_wdata, mem_q,
      input  instr_valid, instr_opcode, instr_operand, instr_len,
             data_valid, data_rdata, data_err, busy, mem_adrs, mem_data, mem_wr_en
   );
endinterface

// File: rtl/mem_access_unit.sv
// CPU-side RAM master serving instruction fetch (1/2-byte auto-length) and load/store.
// Latency: response pulse 2 edges after acceptance (3 for a 2-byte fetch); all outputs registered.
// Backpressure: requests sampled only in IDLE, data before fetch; requesters hold req until accepted.
// Optional macro WR_PROTECT_EN: stores to addresses <= PROT_TOP are suppressed and flagged via data_err.
module mem_access_unit
`ifdef WR_PROTECT_EN
#(
   parameter logic [7:0] PROT_TOP = 8'h3F
)
`endif
(
   input logic               clock,
   input logic               reset_n,
   mem_access_unit_if.master bus
);

   typedef enum logic [2:0] {IDLE, F_OPC, F_OPR, D_RD, D_WR, RESP} state_t;

   state_t     state_q, state_d;
   logic       resp_fetch_q, resp_fetch_d;   // kind of response owed in RESP
   logic       err_q, err_d;                 // current store was rejected

   logic       instr_valid_q, instr_valid_d;
   logic [7:0] instr_opcode_q, instr_opcode_d;
   logic [7:0] instr_operand_q, instr_operand_d;
   logic       instr_len_q, instr_len_d;
   logic       data_valid_q, data_valid_d;
   logic [7:0] data_rdata_q, data_rdata_d;
   logic       data_err_q, data_err_d;
   logic       busy_q, busy_d;
   logic [7:0] mem_adrs_q, mem_adrs_d;
   logic [7:0] mem_data_q, mem_data_d;
   logic       mem_wr_en_q, mem_wr_en_d;

   // Next state and next value of every registered output.
   always_comb begin
      state_d         = state_q;
      resp_fetch_d    = resp_fetch_q;
      err_d           = err_q;
      instr_valid_d   = 1'b0;
      instr_opcode_d  = instr_opcode_q;
      instr_operand_d = instr_operand_q;
      instr_len_d     = instr_len_q;
      data_valid_d    = 1'b0;
      data_rdata_d    = data_rdata_q;
      data_err_d      = 1'b0;
      mem_adrs_d      = mem_adrs_q;
      mem_data_d      = mem_data_q;
      mem_wr_en_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.data_req) begin
               mem_adrs_d   = bus.data_adrs;
               resp_fetch_d = 1'b0;
               err_d        = 1'b0;
               if (bus.data_we) begin
                  mem_data_d  = bus.data_wdata;
                  mem_wr_en_d = 1'b1;
`ifdef WR_PROTECT_EN
                  // Protected store still walks through D_WR, but never strobes the RAM.
                  if (bus.data_adrs <= PROT_TOP) begin
                     mem_wr_en_d = 1'b0;
                     err_d       = 1'b1;
                  end
`endif
                  state_d = D_WR;
               end else begin
                  state_d = D_RD;
               end
            end else if (bus.fetch_req) begin
               mem_adrs_d   = bus.fetch_pc;
               resp_fetch_d = 1'b1;
               state_d      = F_OPC;
            end
         end
         F_OPC: begin
            instr_opcode_d = bus.mem_q;
            if (bus.mem_q[7]) begin
               // Operand follows the opcode; address wraps at 8 bits.
               mem_adrs_d = mem_adrs_q + 8'd1;
               state_d    = F_OPR;
            end else begin
               instr_operand_d = 8'h00;
               instr_len_d     = 1'b0;
               state_d         = RESP;
            end
         end
         F_OPR: begin
            instr_operand_d = bus.mem_q;
            instr_len_d     = 1'b1;
            state_d         = RESP;
         end
         D_RD: begin
            data_rdata_d = bus.mem_q;
            state_d      = RESP;
         end
         D_WR: begin
            state_d = RESP;
         end
         RESP: begin
            if (resp_fetch_q) begin
               instr_valid_d = 1'b1;
            end else begin
               data_valid_d = 1'b1;
               data_err_d   = err_q;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers; synchronous reset clears everything.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         resp_fetch_q    <= 1'b0;
         err_q           <= 1'b0;
         instr_valid_q   <= 1'b0;
         instr_opcode_q  <= 8'h00;
         instr_operand_q <= 8'h00;
         instr_len_q     <= 1'b0;
         data_valid_q    <= 1'b0;
         data_rdata_q    <= 8'h00;
         data_err_q      <= 1'b0;
         busy_q          <= 1'b0;
         mem_adrs_q      <= 8'h00;
         mem_data_q      <= 8'h00;
         mem_wr_en_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         resp_fetch_q    <= resp_fetch_d;
         err_q           <= err_d;
         instr_valid_q   <= instr_valid_d;
         instr_opcode_q  <= instr_opcode_d;
         instr_operand_q <= instr_operand_d;
         instr_len_q     <= instr_len_d;
         data_valid_q    <= data_valid_d;
         data_rdata_q    <= data_rdata_d;
         data_err_q      <= data_err_d;
         busy_q          <= busy_d;
         mem_adrs_q      <= mem_adrs_d;
         mem_data_q      <= mem_data_d;
         mem_wr_en_q     <= mem_wr_en_d;
      end
   end

   assign bus.instr_valid   = instr_valid_q;
   assign bus.instr_opcode  = instr_opcode_q;
   assign bus.instr_operand = instr_operand_q;
   assign bus.instr_len     = instr_len_q;
   assign bus.data_valid    = data_valid_q;
   assign bus.data_rdata    = data_rdata_q;
   assign bus.data_err      = data_err_q;
   assign bus.busy          = busy_q;
   assign bus.mem_adrs      = mem_adrs_q;
   assign bus.mem_data      = mem_data_q;
   assign bus.mem_wr_en     = mem_wr_en_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios followed by random fetch/load/store traffic.
// A 256x8 RAM is modelled here; expected results come from a separate reference memory image.
// Honours WR_PROTECT_EN in the same way as the design build.
module tb_mem_access_unit;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   mem_access_unit_if bus();

   mem_access_unit dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // RAM under the DUT plus a preload port used only while the DUT is idle.
   logic [7:0] ram [256];
   logic       pre_we = 1'b0;
   logic [7:0] pre_a  = 8'h00;
   logic [7:0] pre_d  = 8'h00;
   assign bus.mem_q = ram[bus.mem_adrs];
   always @(posedge clock) begin
      if (pre_we)             ram[pre_a]        <= pre_d;
      else if (bus.mem_wr_en) ram[bus.mem_adrs] <= bus.mem_data;
   end

   // Write-strobe monitor: counts cycles with mem_wr_en high and records the last write.
   int         wr_cnt = 0;
   logic [7:0] wr_a   = 8'h00;
   logic [7:0] wr_d   = 8'h00;
   always @(negedge clock) begin
      if (bus.mem_wr_en === 1'b1) begin
         wr_cnt = wr_cnt + 1;
         wr_a   = bus.mem_adrs;
         wr_d   = bus.mem_data;
      end
   end

   logic [7:0] ref_mem [256];   // expected RAM contents
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pre_we = 1'b1; pre_a = a; pre_d = d;
      ref_mem[a] = d;
      tick();
      pre_we = 1'b0;
   endtask

   // Waits (bounded) for the chosen valid pulse; lat = edges waited.
   task automatic wait_valid(input bit want_instr, output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!((want_instr ? bus.instr_valid : bus.data_valid) === 1'b1) && lat < 10);
   endtask

   function automatic bit is_protected(input logic [7:0] a);
`ifdef WR_PROTECT_EN
      return (a <= 8'h3F);
`else
      return 1'b0;
`endif
   endfunction

   task automatic do_fetch(input logic [7:0] pc);
      logic [7:0] pc1, exp_op, exp_opr;
      logic       exp_len;
      int         lat;
      pc1     = pc + 8'd1;
      exp_op  = ref_mem[pc];
      exp_len = exp_op[7];
      exp_opr = exp_len ? ref_mem[pc1] : 8'h00;
      bus.fetch_req = 1'b1; bus.fetch_pc = pc;
      tick();
      bus.fetch_req = 1'b0;
      check("fetch_busy", 32'(bus.busy), 32'd1);
      check("fetch_adrs", 32'(bus.mem_adrs), 32'(pc));
      tick();
      if (exp_len) check("fetch_opr_adrs", 32'(bus.mem_adrs), 32'(pc1));
      wait_valid(1'b1, lat);
      check("fetch_latency", 32'(lat + 1), exp_len ? 32'd3 : 32'd2);
      check("instr_opcode", 32'(bus.instr_opcode), 32'(exp_op));
      check("instr_operand", 32'(bus.instr_operand), 32'(exp_opr));
      check("instr_len", 32'(bus.instr_len), 32'(exp_len));
      check("fetch_busy_done", 32'(bus.busy), 32'd0);
      tick();
      check("instr_valid_pulse", 32'(bus.instr_valid), 32'd0);
   endtask

   task automatic do_load(input logic [7:0] a);
      int lat;
      bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_adrs = a;
      tick();
      bus.data_req = 1'b0;
      check("load_adrs", 32'(bus.mem_adrs), 32'(a));
      wait_valid(1'b0, lat);
      check("load_latency", 32'(lat), 32'd2);
      check("load_rdata", 32'(bus.data_rdata), 32'(ref_mem[a]));
      check("load_err", 32'(bus.data_err), 32'd0);
      tick();
      check("data_valid_pulse", 32'(bus.data_valid), 32'd0);
   endtask

   task automatic do_store(input logic [7:0] a, input logic [7:0] d);
      int lat, w0;
      bit prot;
      prot = is_protected(a);
      w0   = wr_cnt;
      bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_adrs = a; bus.data_wdata = d;
      tick();
      bus.data_req = 1'b0; bus.data_we = 1'b0;
      wait_valid(1'b0, lat);
      check("store_latency", 32'(lat), 32'd2);
      check("store_err", 32'(bus.data_err), 32'(prot));
      check("store_wr_cycles", 32'(wr_cnt - w0), prot ? 32'd0 : 32'd1);
      if (!prot) begin
         check("store_wr_adrs", 32'(wr_a), 32'(a));
         check("store_wr_data", 32'(wr_d), 32'(d));
         ref_mem[a] = d;
      end
      tick();
      check("store_valid_pulse", 32'(bus.data_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  lat;
      bit  seen;
      bus.fetch_req = 1'b0; bus.fetch_pc = 8'h00;
      bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_adrs = 8'h00; bus.data_wdata = 8'h00;

      // Reset state
      reset_n = 1'b0;
      tick(); tick();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_data_valid", 32'(bus.data_valid), 32'd0);
      check("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
      check("rst_mem_adrs", 32'(bus.mem_adrs), 32'd0);
      check("rst_instr_opcode", 32'(bus.instr_opcode), 32'd0);
      check("rst_data_rdata", 32'(bus.data_rdata), 32'd0);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom_range(255)));

      // 1-byte fetch, 2-byte fetch, wrapped 2-byte fetch
      preload(8'h00, 8'h06);
      do_fetch(8'h00);
      preload(8'h00, 8'h81); preload(8'h01, 8'h07);
      do_fetch(8'h00);
      preload(8'hFF, 8'hC0); preload(8'h00, 8'h05);
      do_fetch(8'hFF);

      // Store then load back
      do_store(8'h09, 8'hA5);
      do_load(8'h09);

      // Simultaneous load and fetch: load wins, fetch held until the next IDLE edge
      preload(8'h00, 8'h06);
      bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_adrs = 8'h09;
      bus.fetch_req = 1'b1; bus.fetch_pc = 8'h00;
      tick();
      bus.data_req = 1'b0;
      check("prio_adrs", 32'(bus.mem_adrs), 32'h09);
      wait_valid(1'b0, lat);
      check("prio_load_latency", 32'(lat), 32'd2);
      check("prio_load_rdata", 32'(bus.data_rdata), 32'(ref_mem[8'h09]));
      check("prio_no_instr_yet", 32'(bus.instr_valid), 32'd0);
      tick();
      bus.fetch_req = 1'b0;
      check("prio_fetch_busy", 32'(bus.busy), 32'd1);
      check("prio_fetch_adrs", 32'(bus.mem_adrs), 32'h00);
      wait_valid(1'b1, lat);
      check("prio_fetch_latency", 32'(lat), 32'd2);
      check("prio_fetch_opcode", 32'(bus.instr_opcode), 32'h06);
      tick();

      // Reset during F_OPR of a 2-byte fetch: no response afterwards
      preload(8'h20, 8'h81); preload(8'h21, 8'h07);
      bus.fetch_req = 1'b1; bus.fetch_pc = 8'h20;
      tick();
      bus.fetch_req = 1'b0;
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_instr_valid", 32'(bus.instr_valid), 32'd0);
      check("midrst_instr_opcode", 32'(bus.instr_opcode), 32'd0);
      check("midrst_mem_adrs", 32'(bus.mem_adrs), 32'd0);
      check("midrst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.instr_valid === 1'b1) seen = 1'b1;
      end
      check("midrst_no_resp", 32'(seen), 32'd0);

      // Protection boundary (expected outcome depends on WR_PROTECT_EN)
      do_store(8'h10, 8'h5A);
      do_load(8'h10);
      do_store(8'h3F, 8'h11);
      do_load(8'h3F);
      do_store(8'h40, 8'h77);
      do_load(8'h40);

      // Random traffic
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(2))
            0:       do_fetch(8'($urandom_range(255)));
            1:       do_load(8'($urandom_range(255)));
            default: do_store(8'($urandom_range(255)), 8'($urandom_range(255)));
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
